lfsr_shift_unit: RTL and testbench

- Parametrised successor to the 8-bit shift register and fixed-tap LFSR.
- A WIDTH-bit register with runtime-selectable mode: load, shift right, shift left, or Fibonacci LFSR with a runtime tap mask.
- Runs a commanded burst of N steps under a start/busy/done handshake.
- Serves as the test-pattern / pseudo-random source and serial converter for the lab datapaths.

---
 rtl/lfsr_pkg.sv | 21 ++
 rtl/lfsr_next_value.sv | 44 ++++
 rtl/lfsr_shift_unit.sv | 120 ++++++++++++
 tb/tb_lfsr_shift_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared types for the shift/LFSR unit.
// Mode and FSM encodings plus the legacy 8-bit tap mask.
package lfsr_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'd0,
    MODE_LOAD = 3'd1,
    MODE_SHR  = 3'd2,
    MODE_SHL  = 3'd3,
    MODE_LFSR = 3'd4
  } mode_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam logic [7:0] DEFAULT_TAPS8 = 8'h27;

endpackage

// File: rtl/lfsr_next_value.sv
// lfsr_next_value: one combinational step of the register.
// Unknown modes hold; next_sout is 0 when nothing shifts.
module lfsr_next_value
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] po,
  input  logic             sin,
  input  logic [WIDTH-1:0] taps,
  input  mode_e            mode,
  output logic [WIDTH-1:0] next_po,
  output logic             next_sout
);

  logic fb;

  assign fb = ^(po & taps);

  // Decode the mode into the next register value and shifted-out bit
  always_comb begin
    next_po   = po;
    next_sout = 1'b0;
    unique case (1'b1)
      (mode == MODE_SHR): begin
        next_po   = {sin, po[WIDTH-1:1]};
        next_sout = po[0];
      end
      (mode == MODE_SHL): begin
        next_po   = {po[WIDTH-2:0], sin};
        next_sout = po[WIDTH-1];
      end
      (mode == MODE_LFSR): begin
        next_po   = {fb, po[WIDTH-1:1]};
        next_sout = po[0];
      end
      default: begin
        next_po   = po;
        next_sout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/lfsr_shift_unit.sv
// lfsr_shift_unit: burst shift register / Fibonacci LFSR.
// Option macro LFSR_LOCKUP_RECOVER_EN reseeds an all-zero LFSR.
module lfsr_shift_unit
  import lfsr_pkg::*;
#(
  parameter int             WIDTH     = 8,
  parameter int             MAX_STEPS = 255,
  parameter logic [WIDTH-1:0] SEED    = {{(WIDTH-1){1'b0}}, 1'b1},
  localparam int            CW        = $clog2(MAX_STEPS + 1)
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             start,
  input  mode_e            mode,
  input  logic [CW-1:0]    steps,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sin,
  input  logic [WIDTH-1:0] taps,
  output logic [WIDTH-1:0] po,
  output logic             sout,
  output logic             busy,
  output logic             done,
  output logic             lockup
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] po_q, po_d;
  logic             sout_q, sout_d;
  logic             lock_q, lock_d;
  logic [WIDTH-1:0] nv_po;
  logic             nv_sout;
  logic             shifting;

  lfsr_next_value #(
    .WIDTH (WIDTH)
  ) u_next (
    .po        (po_q),
    .sin       (sin),
    .taps      (taps),
    .mode      (mode_q),
    .next_po   (nv_po),
    .next_sout (nv_sout)
  );

  assign shifting = (mode_q == MODE_SHR) ||
                    (mode_q == MODE_SHL) ||
                    (mode_q == MODE_LFSR);

  // State, counter and datapath registers
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= MODE_HOLD;
      cnt_q   <= '0;
      po_q    <= SEED;
      sout_q  <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      po_q    <= po_d;
      sout_q  <= sout_d;
      lock_q  <= lock_d;
    end
  end

  // Next-state, counter and register update for the burst FSM
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    po_d    = po_q;
    sout_d  = sout_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mode_d = mode;
          if (mode == MODE_LOAD) begin
            po_d    = load_val;
            state_d = DONE;
          end else if (steps == '0) begin
            state_d = DONE;
          end else begin
            cnt_d   = steps;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        po_d = nv_po;
        if (shifting) sout_d = nv_sout;
`ifdef LFSR_LOCKUP_RECOVER_EN
        if ((mode_q == MODE_LFSR) && (po_q == '0)) begin
          po_d   = SEED;
          sout_d = 1'b0;
        end
`endif
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    lock_d = (po_d == '0) && (mode_d == MODE_LFSR);
  end

  assign po     = po_q;
  assign sout   = sout_q;
  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign lockup = lock_q;

endmodule

// File: tb/tb_lfsr_shift_unit.sv
// tb_lfsr_shift_unit: directed and random bursts vs a reference model.
// Honors LFSR_LOCKUP_RECOVER_EN the same way as the design.
`timescale 1ns/1ps
module tb_lfsr_shift_unit;
  import lfsr_pkg::*;

  logic       CLK = 1'b0;
  logic       rst_n;
  logic       start;
  mode_e      mode;
  logic [7:0] steps;
  logic [7:0] load_val;
  logic       sin;
  logic [7:0] taps;
  logic [7:0] po;
  logic       sout;
  logic       busy;
  logic       done;
  logic       lockup;

  int n_chk  = 0;
  int n_fail = 0;

  int m_po, m_sout, m_lock, m_cmode;

  lfsr_shift_unit u_dut (
    .CLK      (CLK),
    .rst_n    (rst_n),
    .start    (start),
    .mode     (mode),
    .steps    (steps),
    .load_val (load_val),
    .sin      (sin),
    .taps     (taps),
    .po       (po),
    .sout     (sout),
    .busy     (busy),
    .done     (done),
    .lockup   (lockup)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic void mstep(input int s, input int t);
    case (m_cmode)
      2: begin
        m_sout = m_po % 2;
        m_po   = m_po / 2 + s * 128;
      end
      3: begin
        m_sout = m_po / 128;
        m_po   = (m_po * 2) % 256 + s;
      end
      4: begin
`ifdef LFSR_LOCKUP_RECOVER_EN
        if (m_po == 0) begin
          m_po   = 1;
          m_sout = 0;
        end else
`endif
        begin
          m_sout = m_po % 2;
          m_po   = m_po / 2 + ($countones(m_po & t) % 2) * 128;
        end
      end
      default: ;
    endcase
    m_lock = (m_po == 0 && m_cmode == 4) ? 1 : 0;
  endfunction

  task automatic run_cmd(input int md, input int n, input int lv,
                         input bit rnd, input bit s0, input int t0);
    int k;
    logic [2:0] md3;
    md3      = md[2:0];
    start    = 1'b1;
    mode     = mode_e'(md3);
    steps    = n[7:0];
    load_val = lv[7:0];
    sin      = rnd ? 1'($urandom) : s0;
    taps     = rnd ? 8'($urandom) : t0[7:0];
    tick();
    start   = 1'b0;
    m_cmode = md;
    if (md == 1) begin
      m_po = lv & 255;
      k    = 0;
    end else begin
      k = n & 255;
    end
    m_lock = (m_po == 0 && md == 4) ? 1 : 0;
    chk("start_po", po, m_po);
    chk("start_lock", lockup, m_lock);
    chk("start_busy", busy, k > 0);
    chk("start_done", done, k == 0);
    for (int i = 0; i < k; i++) begin
      sin  = rnd ? 1'($urandom) : s0;
      taps = rnd ? 8'($urandom) : t0[7:0];
      if (rnd) begin
        start = 1'($urandom);
        mode  = mode_e'(3'($urandom));
        steps = 8'($urandom);
      end
      mstep(int'(sin), int'(taps));
      tick();
      chk("run_po", po, m_po);
      chk("run_sout", sout, m_sout);
      chk("run_lock", lockup, m_lock);
      chk("run_busy", busy, i < k - 1);
      chk("run_done", done, i == k - 1);
    end
    start = 1'b0;
    tick();
    chk("idle_busy", busy, 1'b0);
    chk("idle_done", done, 1'b0);
    chk("idle_po", po, m_po);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    mode     = MODE_HOLD;
    steps    = '0;
    load_val = '0;
    sin      = 1'b0;
    taps     = '0;
    m_po     = 1;
    m_sout   = 0;
    m_lock   = 0;
    m_cmode  = 0;
    #12;
    chk("rst_po", po, 8'h01);
    chk("rst_sout", sout, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_lock", lockup, 1'b0);
    rst_n = 1'b1;
    tick();

    run_cmd(4, 3, 0, 1'b0, 1'b0, int'(DEFAULT_TAPS8));
    chk("tp1_po", po, 8'h20);

    run_cmd(1, 0, 8'h00, 1'b0, 1'b0, 0);
    run_cmd(2, 3, 0, 1'b0, 1'b1, 0);
    chk("tp2_po", po, 8'hE0);
    chk("tp2_sout", sout, 1'b0);

    run_cmd(1, 0, 8'h81, 1'b0, 1'b0, 0);
    run_cmd(3, 2, 0, 1'b0, 1'b1, 0);
    chk("tp3_po", po, 8'h07);
    chk("tp3_sout", sout, 1'b0);

    run_cmd(2, 0, 0, 1'b0, 1'b1, 0);
    chk("tp4_po_hold", po, 8'h07);
    run_cmd(1, 0, 8'h5A, 1'b0, 1'b0, 0);
    chk("tp4_po_load", po, 8'h5A);

    run_cmd(1, 0, 8'h00, 1'b0, 1'b0, 0);
    run_cmd(4, 2, 0, 1'b0, 1'b0, int'(DEFAULT_TAPS8));
`ifdef LFSR_LOCKUP_RECOVER_EN
    chk("tp5_po", po, 8'h80);
    chk("tp5_lock", lockup, 1'b0);
`else
    chk("tp5_po", po, 8'h00);
    chk("tp5_lock", lockup, 1'b1);
`endif

    start = 1'b1;
    mode  = MODE_LFSR;
    steps = 8'd10;
    taps  = DEFAULT_TAPS8;
    tick();
    repeat (3) tick();
    start = 1'b0;
    chk("tp6_busy_pre", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #0.5;
    chk("tp6_po", po, 8'h01);
    chk("tp6_busy", busy, 1'b0);
    chk("tp6_lock", lockup, 1'b0);
    chk("tp6_sout", sout, 1'b0);
    #0.5;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("tp6_no_done", done, 1'b0);
    end
    chk("tp6_po_after", po, 8'h01);
    m_po    = 1;
    m_sout  = 0;
    m_lock  = 0;
    m_cmode = 0;

    for (int j = 0; j < 60; j++) begin
      int md, n, lv;
      md = int'($urandom_range(0, 7));
      n  = int'($urandom_range(0, 12));
      lv = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255));
      run_cmd(md, n, lv, 1'b1, 1'b0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
